// File: rtl/inst_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared widths and FSM state encoding for the instruction-fetch adapter.
//   INST_ADDR_W : core fetch address width (byte address)
//   INST_W      : instruction word width
//   WORD_ADDR_W : width of a word address (byte address without bits [1:0])
//   if_state_e  : fetch FSM states (IDLE, FETCH, ABORT), 2-bit encoding
// ---------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int WORD_ADDR_W = INST_ADDR_W - 2;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_FETCH = 2'b01,
        IF_ABORT = 2'b10
    } if_state_e;

    // Byte address of byte `idx` inside word `word_addr`.
    function automatic logic [INST_ADDR_W-1:0] byte_addr(
        input logic [WORD_ADDR_W-1:0] word_addr,
        input logic [1:0]             idx
    );
        return {word_addr, idx};
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Serves the core's 32-bit instruction fetch from a byte-wide handshaked
// memory. Four bytes are assembled little-endian into a one-entry word
// buffer; while the requested word is not in the buffer, stallreq_if is high.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-low
//   rom_ce      in   core fetch enable
//   rom_addr    in   core fetch byte address (bits [1:0] ignored)
//   rom_inst    out  instruction word, valid when rom_ce=1 and stallreq_if=0
//   stallreq_if out  stall request to ctrl (combinational)
//   mem_rd      out  byte read request (decoded from registered state)
//   mem_addr    out  byte address of the current read
//   mem_rdata   in   read data, valid when mem_ready=1
//   mem_ready   in   byte acknowledge, may respond in the same cycle as mem_rd
// ---------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce,
    input  logic [INST_ADDR_W-1:0] rom_addr,
    output logic [INST_W-1:0]      rom_inst,
    output logic                   stallreq_if,
    output logic                   mem_rd,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ready
);

    if_state_e              state, state_next;
    logic [1:0]             k;
    logic [WORD_ADDR_W-1:0] req_addr;
    logic [23:0]            asm_data;
    logic                   buf_valid;
    logic [WORD_ADDR_W-1:0] buf_addr;
    logic [INST_W-1:0]      buf_data;

    logic hit;
    logic redirect;
    logic start;
    logic accept;
    logic done;

    // Outputs toward the core are forced quiet while reset is asserted.
    assign hit         = rst & rom_ce & buf_valid & (buf_addr == rom_addr[INST_ADDR_W-1:2]);
    assign rom_inst    = hit ? buf_data : '0;
    assign stallreq_if = rst & rom_ce & ~hit;

    // The core moved away from the word being fetched (branch or flush).
    assign redirect = ~rom_ce | (rom_addr[INST_ADDR_W-1:2] != req_addr);

    // Next-state and memory-side decode. mem_rd/mem_addr depend on registered
    // state only, so there is no combinational path from rom_addr to memory.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        unique case (state)
            IF_IDLE: begin
                if (rom_ce && !hit) begin
                    start      = 1'b1;
                    state_next = IF_FETCH;
                end
            end
            IF_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = byte_addr(req_addr, k);
                if (mem_ready) begin
                    // An accepted byte belongs to the old request; completion
                    // of byte 3 takes priority over a redirect.
                    accept = 1'b1;
                    if (k == 2'd3) begin
                        done       = 1'b1;
                        state_next = IF_IDLE;
                    end else if (redirect) begin
                        state_next = IF_ABORT;
                    end
                end else if (redirect) begin
                    state_next = IF_ABORT;
                end
            end
            IF_ABORT: begin
                // One idle bus cycle, then a fresh miss restarts at byte 0.
                state_next = IF_IDLE;
            end
            default: state_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control registers: byte index and buffer valid are reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k         <= 2'd0;
            buf_valid <= 1'b0;
        end else begin
            if (start) begin
                k <= 2'd0;
            end else if (accept) begin
                k <= k + 2'd1;
            end
            if (done) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // NOTE: data storage is not reset; it is only ever observed through buf_valid or the FETCH state.
    always_ff @(posedge clk) begin
        if (start) begin
            req_addr <= rom_addr[INST_ADDR_W-1:2];
        end
        if (accept) begin
            unique case (k)
                2'd0: asm_data[7:0]   <= mem_rdata;
                2'd1: asm_data[15:8]  <= mem_rdata;
                2'd2: asm_data[23:16] <= mem_rdata;
                2'd3: begin
                    buf_data <= {mem_rdata, asm_data};
                    buf_addr <= req_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Randomised and directed stimulus against a behavioural model of the fetch
// adapter: a byte-array memory, a one-word buffer (valid + word address) and
// the documented latency rule 5 + 4W for a miss, 0 for a hit. Expected words
// are queued when a request is issued and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stallreq_if;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .stallreq_if (stallreq_if),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] acc_q [$];
    int          cur_w = 0;

    // Reference buffer state, tracked at word granularity.
    bit          model_valid = 1'b0;
    logic [29:0] model_base;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    // Memory responder: W wait cycles before each byte, garbage data otherwise.
    int          cnt = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(posedge clk) begin
        #2;
        if (prev_wait && rst) begin
            check("hold_rd", {31'h0, mem_rd}, 32'h1);
            check("hold_addr", mem_addr, prev_addr);
        end
        prev_wait = 1'b0;
        if (mem_rd === 1'b1) begin
            if (cnt < cur_w) begin
                mem_ready = 1'b0;
                mem_rdata = 8'($urandom);
                cnt++;
                prev_wait = rst;
                prev_addr = mem_addr;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
                acc_q.push_back(mem_addr);
                cnt = 0;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            cnt = 0;
        end
    end

    // Monitor: every unstalled enabled cycle consumes one expected word.
    always @(negedge clk) begin
        if (rst === 1'b1 && rom_ce === 1'b1) begin
            if (stallreq_if === 1'b0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got 0x%08h with no request pending at %0t", rom_inst, $time);
                end else begin
                    check("rom_inst", rom_inst, exp_q.pop_front());
                end
            end else begin
                check("rom_inst_stalled", rom_inst, 32'h0);
            end
        end
    end

    // Issue one request at posedge+1 and hold it until the DUT stops stalling.
    task automatic issue(input logic [31:0] a, input int w, input int lat_ovr,
                         input bit has_pre, input logic [31:0] pre);
        int          stalls;
        bit          exp_hit;
        int          exp_lat;
        logic [31:0] base;
        logic [31:0] exp_acc [$];
        stalls  = 0;
        base    = {a[31:2], 2'b00};
        exp_hit = model_valid && (model_base == a[31:2]);
        exp_lat = (lat_ovr >= 0) ? lat_ovr : (exp_hit ? 0 : 5 + 4 * w);
        cur_w   = w;
        acc_q.delete();
        rom_ce   = 1'b1;
        rom_addr = a;
        exp_q.push_back(model_word(a));
        forever begin
            @(negedge clk);
            if (stallreq_if === 1'b0) break;
            stalls++;
            if (stalls > 200) begin
                tests++;
                fails++;
                $display("FAIL timeout: addr 0x%08h still stalled after %0d cycles", a, stalls);
                exp_q.delete();
                break;
            end
            @(posedge clk);
            #1;
        end
        check("latency", 32'(stalls), 32'(exp_lat));
        if (has_pre) exp_acc.push_back(pre);
        if (!exp_hit || lat_ovr >= 0) begin
            for (int i = 0; i < 4; i++) exp_acc.push_back(base + 32'(i));
        end
        check("acc_count", 32'(acc_q.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++) begin
            check("acc_addr", acc_q[i], exp_acc[i]);
        end
        model_valid = 1'b1;
        model_base  = a[31:2];
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input int w);
        issue(a, w, -1, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] last_a;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

        // Reset with a pending fetch request: everything must stay quiet.
        rst      = 1'b0;
        rom_ce   = 1'b1;
        rom_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall", {31'h0, stallreq_if}, 32'h0);
        check("rst_rom_inst", rom_inst, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First fetch at 0x0, then three repeats that must be free hits.
        req(32'h0, 0);
        repeat (3) req(32'h0, 0);

        // Misaligned address and a wait-state fetch.
        req(32'h6, 0);
        req(32'h8, 2);

        // Fetch disabled: no stall and no memory traffic.
        rom_ce   = 1'b0;
        rom_addr = 32'h0000_0044;
        repeat (3) begin
            @(negedge clk);
            check("idle_stall", {31'h0, stallreq_if}, 32'h0);
            check("idle_mem_rd", {31'h0, mem_rd}, 32'h0);
            @(posedge clk);
            #1;
        end

        // Redirect after byte 1 of 0x10: byte 2 still lands, one ABORT cycle,
        // then 0x40 is fetched from byte 0.
        cur_w    = 0;
        rom_ce   = 1'b1;
        rom_addr = 32'h10;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(32'h40, 0, 7, 1'b1, 32'h12);
        req(32'h10, 0);

        // Reset during byte 2 of a fetch of 0x20; 0x10 must then miss.
        rom_addr = 32'h20;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'h0, stallreq_if}, 32'h0);
        check("rst_mid_inst", rom_inst, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_after_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_after_stall", {31'h0, stallreq_if}, 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        model_valid = 1'b0;
        req(32'h10, 0);

        // Random traffic with frequent address reuse and upper-bit aliasing.
        last_a = 32'h10;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                a = last_a;
            end else begin
                a = ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 63));
            end
            req(a, int'($urandom_range(0, 3)));
            last_a = a;
        end

        rom_ce = 1'b0;
        repeat (3) @(posedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
